// File: rtl/i2c_slave_core.sv
// I2C target responder: oversampled, glitch-filtered SCL/SDA front end feeding a
// byte-level FSM that ACKs a fixed 7-bit address and runs write (rx) or read (tx) transfers.
module i2c_slave_core #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       wb_clk_i,
    input  logic       arst_i,
    input  logic       scl_pad_i,
    input  logic       sda_pad_i,
    output logic       sda_pad_o,
    output logic       sda_padoen_o,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       addr_match,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX_BYTE   = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX_BYTE   = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    localparam logic [2:0] FILT_LAST = 3'(FILTER_LEN - 1);

    logic       scl_s1, scl_s2, sda_s1, sda_s2;
    logic [2:0] scl_cnt, sda_cnt;
    logic       scl_f, sda_f, scl_d, sda_d;
    logic       scl_rise, scl_fall, sda_rise, sda_fall;
    logic       start_det, stop_det;

    state_t     state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       rw;
    logic       ack_phase;

    assign sda_pad_o = 1'b0;
    assign state_dbg = state;

    // A filtered level flips only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            scl_s1  <= 1'b1;
            scl_s2  <= 1'b1;
            sda_s1  <= 1'b1;
            sda_s2  <= 1'b1;
            scl_cnt <= 3'd0;
            sda_cnt <= 3'd0;
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_d   <= 1'b1;
            sda_d   <= 1'b1;
        end else begin
            scl_s1 <= scl_pad_i;
            scl_s2 <= scl_s1;
            sda_s1 <= sda_pad_i;
            sda_s2 <= sda_s1;
            scl_d  <= scl_f;
            sda_d  <= sda_f;

            if (scl_s2 == scl_f) begin
                scl_cnt <= 3'd0;
            end else if (scl_cnt == FILT_LAST) begin
                scl_f   <= scl_s2;
                scl_cnt <= 3'd0;
            end else begin
                scl_cnt <= scl_cnt + 3'd1;
            end

            if (sda_s2 == sda_f) begin
                sda_cnt <= 3'd0;
            end else if (sda_cnt == FILT_LAST) begin
                sda_f   <= sda_s2;
                sda_cnt <= 3'd0;
            end else begin
                sda_cnt <= sda_cnt + 3'd1;
            end
        end
    end

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign sda_rise  = sda_f & ~sda_d;
    assign sda_fall  = ~sda_f & sda_d;
    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state        <= ST_IDLE;
            shreg        <= 8'h00;
            bit_cnt      <= 3'd0;
            rw           <= 1'b0;
            ack_phase    <= 1'b0;
            sda_padoen_o <= 1'b1;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            tx_req       <= 1'b0;
            busy         <= 1'b0;
            addr_match   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            // The transmit byte is captured in the same cycle the request strobe is high.
            if (tx_req) begin
                shreg <= tx_data;
            end

            if (start_det) begin
                state        <= ST_ADDR;
                bit_cnt      <= 3'd0;
                sda_padoen_o <= 1'b1;
                busy         <= 1'b1;
                addr_match   <= 1'b0;
            end else if (stop_det) begin
                state        <= ST_IDLE;
                sda_padoen_o <= 1'b1;
                busy         <= 1'b0;
                addr_match   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        sda_padoen_o <= 1'b1;
                    end
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shreg <= {shreg[6:0], sda_f};
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= 3'd0;
                                if (shreg[6:0] == SLAVE_ADDR) begin
                                    state     <= ST_ADDR_ACK;
                                    rw        <= sda_f;
                                    tx_req    <= sda_f;
                                    ack_phase <= 1'b0;
                                end else begin
                                    state <= ST_WAIT_STOP;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 3'd0;
                            if (!ack_phase) begin
                                sda_padoen_o <= 1'b0;
                                addr_match   <= 1'b1;
                                ack_phase    <= 1'b1;
                            end else if (rw) begin
                                sda_padoen_o <= shreg[7];
                                state        <= ST_TX_BYTE;
                            end else begin
                                sda_padoen_o <= 1'b1;
                                state        <= ST_RX_BYTE;
                            end
                        end
                    end
                    ST_RX_BYTE: begin
                        if (scl_rise) begin
                            shreg <= {shreg[6:0], sda_f};
                            if (bit_cnt == 3'd7) begin
                                bit_cnt   <= 3'd0;
                                rx_data   <= {shreg[6:0], sda_f};
                                rx_valid  <= 1'b1;
                                ack_phase <= 1'b0;
                                state     <= ST_RX_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    ST_RX_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_padoen_o <= 1'b0;
                                ack_phase    <= 1'b1;
                            end else begin
                                sda_padoen_o <= 1'b1;
                                bit_cnt      <= 3'd0;
                                state        <= ST_RX_BYTE;
                            end
                        end
                    end
                    ST_TX_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_padoen_o <= 1'b1;
                                bit_cnt      <= 3'd0;
                                ack_phase    <= 1'b0;
                                state        <= ST_TX_ACK;
                            end else begin
                                sda_padoen_o <= shreg[6];
                                shreg        <= {shreg[6:0], 1'b0};
                                bit_cnt      <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    ST_TX_ACK: begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                tx_req    <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                sda_padoen_o <= 1'b1;
                                state        <= ST_WAIT_STOP;
                            end
                        end else if (scl_fall && ack_phase) begin
                            sda_padoen_o <= shreg[7];
                            bit_cnt      <= 3'd0;
                            state        <= ST_TX_BYTE;
                        end
                    end
                    ST_WAIT_STOP: begin
                        sda_padoen_o <= 1'b1;
                    end
                    default: begin
                        state        <= ST_IDLE;
                        sda_padoen_o <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core: a bit-banged I2C master on a wired-AND SDA line.
module tb_i2c_slave_core;

    localparam int Q    = 10;
    localparam int HALF = 20;

    logic       clk;
    logic       arst_n;
    logic       master_scl;
    logic       master_sda;
    logic       sda_line;
    logic       sda_pad_o;
    logic       sda_padoen_o;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       busy;
    logic       addr_match;
    logic [2:0] state_dbg;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sda_line = sda_padoen_o ? master_sda : sda_pad_o;

    i2c_slave_core #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
        .wb_clk_i     (clk),
        .arst_i       (arst_n),
        .scl_pad_i    (master_scl),
        .sda_pad_i    (sda_line),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_req       (tx_req),
        .tx_data      (tx_data),
        .busy         (busy),
        .addr_match   (addr_match),
        .state_dbg    (state_dbg)
    );

    // Transmit bytes handed out in order, one per tx_req strobe.
    logic [7:0] tx_tab [0:3] = '{8'hA5, 8'h5A, 8'hC3, 8'h00};
    int  tx_idx = 0;
    int  tx_req_cnt = 0;
    bit  pop_pending = 1'b0;
    int  rx_cnt = 0;
    logic [7:0] rx_last = 8'h00;
    int  oen_low_cnt = 0;
    int  busy_fall_cnt = 0;
    logic busy_prev = 1'b0;
    int  long_strobe_cnt = 0;
    logic rxv_prev = 1'b0;
    logic txr_prev = 1'b0;

    assign tx_data = (tx_idx < 4) ? tx_tab[tx_idx[1:0]] : 8'hFF;

    always @(negedge clk) begin
        if (pop_pending) begin
            tx_idx      = tx_idx + 1;
            pop_pending = 1'b0;
        end
        if (tx_req) begin
            tx_req_cnt  = tx_req_cnt + 1;
            pop_pending = 1'b1;
        end
        if (rx_valid) begin
            rx_cnt  = rx_cnt + 1;
            rx_last = rx_data;
        end
        if (!sda_padoen_o) oen_low_cnt = oen_low_cnt + 1;
        if (busy_prev && !busy) busy_fall_cnt = busy_fall_cnt + 1;
        if ((rx_valid && rxv_prev) || (tx_req && txr_prev)) long_strobe_cnt = long_strobe_cnt + 1;
        busy_prev = busy;
        rxv_prev  = rx_valid;
        txr_prev  = tx_req;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Works as START from idle and as repeated START with SCL low.
    task automatic bus_start();
        master_sda = 1'b1; tick(Q);
        master_scl = 1'b1; tick(Q);
        master_sda = 1'b0; tick(Q);
        master_scl = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        master_sda = 1'b0; tick(Q);
        master_scl = 1'b1; tick(Q);
        master_sda = 1'b1; tick(HALF);
    endtask

    task automatic write_bit(input logic b);
        master_sda = b;    tick(Q);
        master_scl = 1'b1; tick(HALF);
        master_scl = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        master_sda = 1'b1; tick(Q);
        master_scl = 1'b1; tick(Q);
        b = sda_line;      tick(Q);
        master_scl = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    // Scenarios
    task automatic test_reset();
        vec_cnt++; if (sda_padoen_o !== 1'b1) begin err_cnt++; $display("FAIL reset_oen: got %b expected 1", sda_padoen_o); end
        vec_cnt++; if (sda_pad_o !== 1'b0) begin err_cnt++; $display("FAIL reset_sda_o: got %b expected 0", sda_pad_o); end
        vec_cnt++; if (rx_data !== 8'h00) begin err_cnt++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        vec_cnt++; if (tx_req !== 1'b0) begin err_cnt++; $display("FAIL reset_tx_req: got %b expected 0", tx_req); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vec_cnt++; if (addr_match !== 1'b0) begin err_cnt++; $display("FAIL reset_addr_match: got %b expected 0", addr_match); end
        vec_cnt++; if (state_dbg !== 3'd0) begin err_cnt++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    endtask

    task automatic test_write();
        logic ack;
        int rx0, bf0;
        rx0 = rx_cnt; bf0 = busy_fall_cnt;
        bus_start();
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL wr_busy_start: got %b expected 1", busy); end
        write_byte(8'hA0, ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL wr_addr_ack: got %b expected 0", ack); end
        vec_cnt++; if (addr_match !== 1'b1) begin err_cnt++; $display("FAIL wr_addr_match: got %b expected 1", addr_match); end
        write_byte(8'h3C, ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL wr_data_ack: got %b expected 0", ack); end
        vec_cnt++; if (busy_fall_cnt - bf0 !== 0) begin err_cnt++; $display("FAIL wr_busy_hold: got %0d drops expected 0", busy_fall_cnt - bf0); end
        bus_stop();
        vec_cnt++; if (rx_cnt - rx0 !== 1) begin err_cnt++; $display("FAIL wr_rx_count: got %0d expected 1", rx_cnt - rx0); end
        vec_cnt++; if (rx_last !== 8'h3C) begin err_cnt++; $display("FAIL wr_rx_strobe_data: got %h expected 3c", rx_last); end
        vec_cnt++; if (rx_data !== 8'h3C) begin err_cnt++; $display("FAIL wr_rx_data_held: got %h expected 3c", rx_data); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL wr_busy_stop: got %b expected 0", busy); end
        vec_cnt++; if (addr_match !== 1'b0) begin err_cnt++; $display("FAIL wr_addr_match_stop: got %b expected 0", addr_match); end
        vec_cnt++; if (sda_padoen_o !== 1'b1) begin err_cnt++; $display("FAIL wr_oen_stop: got %b expected 1", sda_padoen_o); end
    endtask

    task automatic test_mismatch();
        logic ack;
        int rx0, ol0;
        rx0 = rx_cnt; ol0 = oen_low_cnt;
        bus_start();
        write_byte(8'hA2, ack);
        vec_cnt++; if (ack !== 1'b1) begin err_cnt++; $display("FAIL mm_addr_nack: got %b expected 1", ack); end
        vec_cnt++; if (addr_match !== 1'b0) begin err_cnt++; $display("FAIL mm_addr_match: got %b expected 0", addr_match); end
        write_byte(8'h55, ack);
        vec_cnt++; if (ack !== 1'b1) begin err_cnt++; $display("FAIL mm_data_nack: got %b expected 1", ack); end
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL mm_busy: got %b expected 1", busy); end
        bus_stop();
        vec_cnt++; if (oen_low_cnt - ol0 !== 0) begin err_cnt++; $display("FAIL mm_sda_driven: got %0d cycles expected 0", oen_low_cnt - ol0); end
        vec_cnt++; if (rx_cnt - rx0 !== 0) begin err_cnt++; $display("FAIL mm_rx_count: got %0d expected 0", rx_cnt - rx0); end
        vec_cnt++; if (state_dbg !== 3'd0) begin err_cnt++; $display("FAIL mm_state_idle: got %0d expected 0", state_dbg); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL mm_busy_stop: got %b expected 0", busy); end
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] d;
        int tr0;
        tr0 = tx_req_cnt;
        bus_start();
        write_byte(8'hA1, ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL rd_addr_ack: got %b expected 0", ack); end
        vec_cnt++; if (addr_match !== 1'b1) begin err_cnt++; $display("FAIL rd_addr_match: got %b expected 1", addr_match); end
        read_byte(d, 1'b0);
        vec_cnt++; if (d !== 8'hA5) begin err_cnt++; $display("FAIL rd_byte1: got %h expected a5", d); end
        read_byte(d, 1'b1);
        vec_cnt++; if (d !== 8'h5A) begin err_cnt++; $display("FAIL rd_byte2: got %h expected 5a", d); end
        vec_cnt++; if (sda_padoen_o !== 1'b1) begin err_cnt++; $display("FAIL rd_release_after_nack: got %b expected 1", sda_padoen_o); end
        vec_cnt++; if (state_dbg !== 3'd7) begin err_cnt++; $display("FAIL rd_wait_stop: got %0d expected 7", state_dbg); end
        bus_stop();
        vec_cnt++; if (tx_req_cnt - tr0 !== 2) begin err_cnt++; $display("FAIL rd_tx_req_count: got %0d expected 2", tx_req_cnt - tr0); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rd_busy_stop: got %b expected 0", busy); end
    endtask

    task automatic test_repeated_start();
        logic ack;
        logic [7:0] d;
        int rx0, tr0, bf0;
        rx0 = rx_cnt; tr0 = tx_req_cnt; bf0 = busy_fall_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL rs_addr1_ack: got %b expected 0", ack); end
        write_byte(8'h01, ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL rs_data_ack: got %b expected 0", ack); end
        bus_start();
        vec_cnt++; if (addr_match !== 1'b0) begin err_cnt++; $display("FAIL rs_match_cleared: got %b expected 0", addr_match); end
        vec_cnt++; if (state_dbg !== 3'd1) begin err_cnt++; $display("FAIL rs_state_addr: got %0d expected 1", state_dbg); end
        write_byte(8'hA1, ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL rs_addr2_ack: got %b expected 0", ack); end
        read_byte(d, 1'b1);
        vec_cnt++; if (d !== 8'hC3) begin err_cnt++; $display("FAIL rs_read_byte: got %h expected c3", d); end
        vec_cnt++; if (busy_fall_cnt - bf0 !== 0) begin err_cnt++; $display("FAIL rs_busy_hold: got %0d drops expected 0", busy_fall_cnt - bf0); end
        bus_stop();
        vec_cnt++; if (rx_data !== 8'h01) begin err_cnt++; $display("FAIL rs_rx_data: got %h expected 01", rx_data); end
        vec_cnt++; if (rx_cnt - rx0 !== 1) begin err_cnt++; $display("FAIL rs_rx_count: got %0d expected 1", rx_cnt - rx0); end
        vec_cnt++; if (tx_req_cnt - tr0 !== 1) begin err_cnt++; $display("FAIL rs_tx_req_count: got %0d expected 1", tx_req_cnt - tr0); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rs_busy_stop: got %b expected 0", busy); end
    endtask

    task automatic test_glitch();
        logic ack;
        int rx0, bf0;
        rx0 = rx_cnt; bf0 = busy_fall_cnt;
        bus_start();
        // Address 0xA0: bit7=1 with a 2-cycle SDA dip, bit6=0 with a 1-cycle SCL low glitch.
        master_sda = 1'b1; tick(Q);
        master_scl = 1'b1; tick(5);
        master_sda = 1'b0; tick(2);
        master_sda = 1'b1; tick(13);
        master_scl = 1'b0; tick(Q);
        master_sda = 1'b0; tick(Q);
        master_scl = 1'b1; tick(5);
        master_scl = 1'b0; tick(1);
        master_scl = 1'b1; tick(14);
        master_scl = 1'b0; tick(Q);
        write_bit(1'b1);
        for (int i = 0; i < 5; i++) write_bit(1'b0);
        read_bit(ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL gl_addr_ack: got %b expected 0", ack); end
        write_byte(8'h77, ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL gl_data_ack: got %b expected 0", ack); end
        vec_cnt++; if (busy_fall_cnt - bf0 !== 0) begin err_cnt++; $display("FAIL gl_no_stop: got %0d drops expected 0", busy_fall_cnt - bf0); end
        bus_stop();
        vec_cnt++; if (rx_cnt - rx0 !== 1) begin err_cnt++; $display("FAIL gl_rx_count: got %0d expected 1", rx_cnt - rx0); end
        vec_cnt++; if (rx_data !== 8'h77) begin err_cnt++; $display("FAIL gl_rx_data: got %h expected 77", rx_data); end
    endtask

    task automatic test_reset_mid_byte();
        logic ack;
        bus_start();
        write_byte(8'hA1, ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL rm_addr_ack: got %b expected 0", ack); end
        vec_cnt++; if (sda_padoen_o !== 1'b0) begin err_cnt++; $display("FAIL rm_driving_zero: got %b expected 0", sda_padoen_o); end
        arst_n = 1'b0;
        #1;
        vec_cnt++; if (sda_padoen_o !== 1'b1) begin err_cnt++; $display("FAIL rm_async_release: got %b expected 1", sda_padoen_o); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rm_busy: got %b expected 0", busy); end
        vec_cnt++; if (state_dbg !== 3'd0) begin err_cnt++; $display("FAIL rm_state: got %0d expected 0", state_dbg); end
        tick(2);
        master_sda = 1'b1; tick(Q);
        master_scl = 1'b1; tick(HALF);
        arst_n = 1'b1;
        tick(HALF);
        bus_start();
        write_byte(8'hA0, ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL rm_post_addr_ack: got %b expected 0", ack); end
        write_byte(8'h42, ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL rm_post_data_ack: got %b expected 0", ack); end
        bus_stop();
        vec_cnt++; if (rx_data !== 8'h42) begin err_cnt++; $display("FAIL rm_post_rx_data: got %h expected 42", rx_data); end
        vec_cnt++; if (long_strobe_cnt !== 0) begin err_cnt++; $display("FAIL strobe_width: got %0d wide strobes expected 0", long_strobe_cnt); end
    endtask

    initial begin
        arst_n     = 1'b0;
        master_scl = 1'b1;
        master_sda = 1'b1;
        tick(5);
        test_reset();
        arst_n = 1'b1;
        tick(10);
        test_write();
        test_mismatch();
        test_read();
        test_repeated_start();
        test_glitch();
        test_reset_mid_byte();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
